// File: rtl/re_buf_sched_if.sv
// re_buf_sched_if: handshake and status bundle between the RE buffer
// scheduler and its surroundings (upstream FFT/demapper, buffer strobes,
// downstream channel-estimation/demod stage).
// Optional macro RE_BUF_SCHED_LEVEL_EN adds the buffer occupancy signal.
interface re_buf_sched_if #(
  parameter int BLK_W = 4
`ifdef RE_BUF_SCHED_LEVEL_EN
  , parameter int CNT_W = 8
`endif
);
  logic             in_valid;
  logic             in_sos;
  logic             in_ready;
  logic             dn_ready;
  logic             buf_push;
  logic             buf_pop;
  logic             out_valid;
  logic             out_last;
  logic             busy;
  logic [BLK_W-1:0] blk_cnt;
  logic             err_ovf;
  logic             err_sos;
`ifdef RE_BUF_SCHED_LEVEL_EN
  logic [CNT_W-1:0] level;

  modport master (
    output in_valid, in_sos, dn_ready,
    input  in_ready, buf_push, buf_pop, out_valid, out_last, busy,
           blk_cnt, err_ovf, err_sos, level
  );

  modport slave (
    input  in_valid, in_sos, dn_ready,
    output in_ready, buf_push, buf_pop, out_valid, out_last, busy,
           blk_cnt, err_ovf, err_sos, level
  );
`else
  modport master (
    output in_valid, in_sos, dn_ready,
    input  in_ready, buf_push, buf_pop, out_valid, out_last, busy,
           blk_cnt, err_ovf, err_sos
  );

  modport slave (
    input  in_valid, in_sos, dn_ready,
    output in_ready, buf_push, buf_pop, out_valid, out_last, busy,
           blk_cnt, err_ovf, err_sos
  );
`endif
endinterface

// File: rtl/re_buf_sched.sv
// re_buf_sched: fill-then-drain sequencer for the post-FFT I/Q RE buffer.
// Fills one block of BLK_LEN entries, then drains it under dn_ready flow
// control. Push and pop are never asserted together. Keeps a wrapping
// completed-block count and sticky overflow / stray-start error flags.
// Optional macro RE_BUF_SCHED_LEVEL_EN adds a registered occupancy output.
module re_buf_sched #(
  parameter int DEPTH   = 144,
  parameter int BLK_LEN = 144,
  parameter int CNT_W   = 8,
  parameter int BLK_W   = 4
) (
  input  logic          clk,
  input  logic          rst,
  re_buf_sched_if.slave io_bus
);

  // Block length held inside 1..DEPTH so the buffer can never overflow.
  localparam int LEN = (BLK_LEN > DEPTH) ? DEPTH : ((BLK_LEN < 1) ? 1 : BLK_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_wr_cnt;
  logic [CNT_W-1:0] w_wr_cnt_nxt;
  logic [CNT_W-1:0] r_rd_cnt;
  logic [CNT_W-1:0] w_rd_cnt_nxt;
  logic             w_push;
  logic             w_pop;
  logic             w_rd_last;
  logic             w_in_ready;
  logic             r_out_valid;
  logic             r_out_last;
  logic [BLK_W-1:0] r_blk_cnt;
  logic             r_err_ovf;
  logic             r_err_sos;

  // State register and entry counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_wr_cnt <= {CNT_W{1'b0}};
      r_rd_cnt <= {CNT_W{1'b0}};
    end else begin
      r_state  <= w_state_nxt;
      r_wr_cnt <= w_wr_cnt_nxt;
      r_rd_cnt <= w_rd_cnt_nxt;
    end
  end

  // Next state, buffer strobes and counter updates; a start in IDLE is the
  // first entry of a block, so a one-entry block goes straight to DRAIN.
  always_comb begin
    w_state_nxt  = r_state;
    w_wr_cnt_nxt = r_wr_cnt;
    w_rd_cnt_nxt = r_rd_cnt;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_rd_last    = 1'b0;
    w_in_ready   = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (io_bus.in_valid && io_bus.in_sos) begin
          w_push = 1'b1;
          if (r_wr_cnt == LAST_IDX) begin
            w_wr_cnt_nxt = {CNT_W{1'b0}};
            w_state_nxt  = ST_DRAIN;
          end else begin
            w_wr_cnt_nxt = r_wr_cnt + CNT_W'(1);
            w_state_nxt  = ST_FILL;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (io_bus.in_valid) begin
          w_push = 1'b1;
          if (r_wr_cnt == LAST_IDX) begin
            w_wr_cnt_nxt = {CNT_W{1'b0}};
            w_state_nxt  = ST_DRAIN;
          end else begin
            w_wr_cnt_nxt = r_wr_cnt + CNT_W'(1);
          end
        end else begin
          w_wr_cnt_nxt = r_wr_cnt;
        end
      end
      ST_DRAIN: begin
        w_in_ready = 1'b0;
        if (io_bus.dn_ready) begin
          w_pop = 1'b1;
          if (r_rd_cnt == LAST_IDX) begin
            w_rd_last    = 1'b1;
            w_rd_cnt_nxt = {CNT_W{1'b0}};
            w_state_nxt  = ST_IDLE;
          end else begin
            w_rd_cnt_nxt = r_rd_cnt + CNT_W'(1);
          end
        end else begin
          w_rd_cnt_nxt = r_rd_cnt;
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_wr_cnt_nxt = {CNT_W{1'b0}};
        w_rd_cnt_nxt = {CNT_W{1'b0}};
      end
    endcase
  end

  // Output-valid alignment with the buffer's registered read port, block
  // count and sticky error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_blk_cnt   <= {BLK_W{1'b0}};
      r_err_ovf   <= 1'b0;
      r_err_sos   <= 1'b0;
    end else begin
      r_out_valid <= w_pop;
      r_out_last  <= w_rd_last;
      if (w_rd_last) begin
        r_blk_cnt <= r_blk_cnt + BLK_W'(1);
      end
      if (io_bus.in_valid && !w_in_ready) begin
        r_err_ovf <= 1'b1;
      end
      if ((r_state == ST_FILL) && io_bus.in_valid && io_bus.in_sos) begin
        r_err_sos <= 1'b1;
      end
    end
  end

`ifdef RE_BUF_SCHED_LEVEL_EN
  logic [CNT_W-1:0] r_level;

  // Buffer occupancy; push and pop are mutually exclusive.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_level <= {CNT_W{1'b0}};
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + CNT_W'(1);
        2'b01:   r_level <= r_level - CNT_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign io_bus.level = r_level;
`endif

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.buf_push  = w_push;
  assign io_bus.buf_pop   = w_pop;
  assign io_bus.busy      = (r_state != ST_IDLE);
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_last  = r_out_last;
  assign io_bus.blk_cnt   = r_blk_cnt;
  assign io_bus.err_ovf   = r_err_ovf;
  assign io_bus.err_sos   = r_err_sos;

endmodule

// File: tb/tb_re_buf_sched.sv
// tb_re_buf_sched: randomized scoreboard bench for re_buf_sched.
// Instance 0 uses 144-entry blocks, instance 1 uses 1-entry blocks. The bench
// models the RE buffer itself (data queue + registered read port) so data
// order through push/pop can be checked against a transaction-level model.
`timescale 1ns/1ps
module tb_re_buf_sched;

  typedef struct {
    int     data;
    bit     last;
    longint due;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  longint cyc = 0;
  int     n_chk = 0;
  int     n_pass = 0;

  // Reference model state, one slot per instance (0 = idle, 1 = fill, 2 = drain).
  int   blen[2] = '{144, 1};
  int   m_st[2];
  int   m_wr[2];
  int   m_rd[2];
  int   m_blk[2];
  int   m_lvl[2];
  bit   m_ovf[2];
  bit   m_sos[2];
  int   m_q[2][$];
  exp_t exp_q[2][$];

  // Buffer stand-in per instance.
  int   env_q[2][$];
  int   bd[2];
  int   indata[2];

  re_buf_sched_if bif ();
  re_buf_sched_if sif ();

  re_buf_sched #(.DEPTH(144), .BLK_LEN(144), .CNT_W(8), .BLK_W(4)) u_dut0 (
    .clk(clk), .rst(rst), .io_bus(bif.slave)
  );
  re_buf_sched #(.DEPTH(144), .BLK_LEN(1), .CNT_W(8), .BLK_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .io_bus(sif.slave)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int k, input longint act, input longint expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s dut%0d: got %0d, expected %0d (cycle %0d)", name, k, act, expv, cyc);
  endtask

  // Buffer stand-in for instance 0.
  always @(posedge clk or negedge rst) begin
    if (!rst) env_q[0].delete();
    else begin
      if (bif.buf_push) env_q[0].push_back(indata[0]);
      if (bif.buf_pop) bd[0] <= (env_q[0].size() > 0) ? env_q[0].pop_front() : -1;
    end
  end

  // Buffer stand-in for instance 1.
  always @(posedge clk or negedge rst) begin
    if (!rst) env_q[1].delete();
    else begin
      if (sif.buf_push) env_q[1].push_back(indata[1]);
      if (sif.buf_pop) bd[1] <= (env_q[1].size() > 0) ? env_q[1].pop_front() : -1;
    end
  end

  task automatic check_out(input int k, input logic ov, input logic ol, input int d);
    exp_t e;
    if (exp_q[k].size() > 0 && exp_q[k][0].due <= cyc) begin
      e = exp_q[k].pop_front();
      chk("out_valid", k, ov, 1);
      chk("out_last", k, ol, e.last);
      chk("out_data", k, d, e.data);
    end else if (ov) begin
      chk("unexpected_out_valid", k, ov, 0);
    end
  endtask

  // Output monitors.
  always @(negedge clk) if (rst) check_out(0, bif.out_valid, bif.out_last, bd[0]);
  always @(negedge clk) if (rst) check_out(1, sif.out_valid, sif.out_last, bd[1]);

  task automatic drive(input int k, input bit v, input bit s, input bit d);
    if (k == 0) begin
      bif.in_valid = v; bif.in_sos = s; bif.dn_ready = d;
    end else begin
      sif.in_valid = v; sif.in_sos = s; sif.dn_ready = d;
    end
  endtask

  // One clock of stimulus on instance k: check visible outputs against the
  // model, then advance the model by the rules for this cycle's inputs.
  task automatic step(input int k, input bit v, input bit s, input bit d);
    logic rdy, psh, pop, bsy, eo, es;
    logic [3:0] bc;
    int lv;
    bit e_push, e_pop;
    exp_t e;
    @(negedge clk);
    indata[k] = int'($urandom_range(0, 65535));
    drive(k, v, s, d);
    #1;
    if (k == 0) begin
      rdy = bif.in_ready; psh = bif.buf_push; pop = bif.buf_pop; bsy = bif.busy;
      bc = bif.blk_cnt; eo = bif.err_ovf; es = bif.err_sos;
`ifdef RE_BUF_SCHED_LEVEL_EN
      lv = int'(bif.level);
`endif
    end else begin
      rdy = sif.in_ready; psh = sif.buf_push; pop = sif.buf_pop; bsy = sif.busy;
      bc = sif.blk_cnt; eo = sif.err_ovf; es = sif.err_sos;
`ifdef RE_BUF_SCHED_LEVEL_EN
      lv = int'(sif.level);
`endif
    end
    e_push = v && (m_st[k] == 1 || (m_st[k] == 0 && s));
    e_pop  = (m_st[k] == 2) && d;
    chk("in_ready", k, rdy, m_st[k] != 2);
    chk("buf_push", k, psh, e_push);
    chk("buf_pop", k, pop, e_pop);
    chk("busy", k, bsy, m_st[k] != 0);
    chk("blk_cnt", k, bc, m_blk[k] % 16);
    chk("err_ovf", k, eo, m_ovf[k]);
    chk("err_sos", k, es, m_sos[k]);
`ifdef RE_BUF_SCHED_LEVEL_EN
    chk("level", k, lv, m_lvl[k]);
`endif
    if (v && m_st[k] == 2) m_ovf[k] = 1'b1;
    if (v && s && m_st[k] == 1) m_sos[k] = 1'b1;
    if (e_push) begin
      m_q[k].push_back(indata[k]);
      m_wr[k]++;
      m_lvl[k]++;
      if (m_wr[k] == blen[k]) begin
        m_wr[k] = 0;
        m_st[k] = 2;
      end else begin
        m_st[k] = 1;
      end
    end else if (e_pop) begin
      m_rd[k]++;
      m_lvl[k]--;
      e.data = m_q[k].pop_front();
      e.last = (m_rd[k] == blen[k]);
      e.due  = cyc + 1;
      exp_q[k].push_back(e);
      if (e.last) begin
        m_rd[k] = 0;
        m_blk[k]++;
        m_st[k] = 0;
      end
    end
  endtask

  // One block: `pre` stray valids in idle, then a start, fill with pv% valid,
  // drain with pd% ready; optional stray sos, overflow burst, early stop.
  task automatic run_block(input int k, input int pre, input int pv, input int pd,
                           input int sos_at, input int ovf_n, input int stop_rd);
    bit started = 1'b0;
    bit done = 1'b0;
    int ovf_left = ovf_n;
    bit v, s, d;
    for (int c = 0; c < 20000; c++) begin
      if (started && m_st[k] == 0) begin done = 1'b1; break; end
      if (stop_rd >= 0 && m_st[k] == 2 && m_rd[k] == stop_rd) begin done = 1'b1; break; end
      v = 1'b0; s = 1'b0;
      d = ($urandom_range(0, 99) < pd);
      if (m_st[k] == 0) begin
        v = 1'b1;
        if (c >= pre) begin s = 1'b1; started = 1'b1; end
      end else if (m_st[k] == 1) begin
        v = ($urandom_range(0, 99) < pv);
        s = v && (m_wr[k] == sos_at);
      end else if (ovf_left > 0) begin
        v = 1'b1;
        ovf_left--;
      end
      step(k, v, s, d);
    end
    chk("block_done", k, done, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("rst_out_valid", 0, bif.out_valid, 0);
    chk("rst_out_last", 0, bif.out_last, 0);
    chk("rst_blk_cnt", 0, bif.blk_cnt, 0);
    chk("rst_busy", 0, bif.busy, 0);
    chk("rst_in_ready", 0, bif.in_ready, 1);
    chk("rst_err_ovf", 0, bif.err_ovf, 0);
    chk("rst_err_sos", 0, bif.err_sos, 0);
    chk("rst_buf_pop", 0, bif.buf_pop, 0);
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_wr[k] = 0; m_rd[k] = 0; m_blk[k] = 0; m_lvl[k] = 0;
      m_ovf[k] = 1'b0; m_sos[k] = 1'b0;
      m_q[k].delete();
      exp_q[k].delete();
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Hard time limit.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Test sequence.
  initial begin
    drive(0, 1'b0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0);
    do_reset();
    step(0, 1'b0, 1'b0, 1'b0);
    step(0, 1'b0, 1'b0, 1'b0);
    run_block(0, 2, 100, 100, -1, 0, -1);   // basic back-to-back block
    run_block(0, 0, 50, 30, -1, 0, -1);     // gappy traffic
    run_block(0, 0, 100, 100, -1, 5, -1);   // overflow during drain
    run_block(0, 0, 100, 100, 50, 0, -1);   // stray sos mid-fill
    run_block(0, 0, 100, 100, -1, 0, 70);   // stop after 70 pops
    step(0, 1'b0, 1'b1, 1'b1);
    do_reset();
    run_block(0, 0, 100, 100, -1, 0, -1);   // normal block after reset
    run_block(1, 0, 100, 100, -1, 0, -1);   // one-entry blocks
    run_block(1, 0, 100, 100, -1, 0, -1);
    repeat (3) step(1, 1'b0, 1'b0, 1'b0);
    repeat (2) step(0, 1'b0, 1'b0, 1'b0);
    chk("exp_q_drained", 0, exp_q[0].size(), 0);
    chk("exp_q_drained", 1, exp_q[1].size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/re_buf_sched.md
Name: re_buf_sched

Overview:
- Sequencer for the 144-entry post-FFT I/Q resource-element buffer.
- Accepts REs from the FFT/demapper and fills the buffer with one block of BLK_LEN entries, then drains that block to the channel-estimation/demod stage under downstream flow control.
- Drives the buffer's push/pop. It never asserts push and pop in the same cycle, so the buffer's simultaneous push/pop path is never exercised.
- Tracks block boundaries, raises last-entry marking, and keeps sticky error flags.

Parameters:
- DEPTH, 144, physical buffer depth in entries.
- BLK_LEN, 144, entries per block; legal range 1..DEPTH.
- CNT_W, 8, width of entry counters; must satisfy 2^CNT_W > DEPTH.
- BLK_W, 4, width of completed-block counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream RE present this cycle
- in_sos  in  1  start-of-block marker, qualified by in_valid
- in_ready  out  1  scheduler accepts an RE this cycle
- dn_ready  in  1  downstream may receive one entry next cycle
- buf_push  out  1  combinational push strobe to buffer
- buf_pop  out  1  combinational pop strobe to buffer
- out_valid  out  1  buffer output register holds a popped entry this cycle
- out_last  out  1  with out_valid: final entry of block
- busy  out  1  high in FILL or DRAIN
- blk_cnt  out  BLK_W  completed blocks, wraps modulo 2^BLK_W
- err_ovf  out  1  sticky: in_valid while in_ready low
- err_sos  out  1  sticky: in_sos seen mid-FILL

Behaviour:
- Reset values: state=IDLE, wr_cnt=0, rd_cnt=0, out_valid=0, out_last=0, blk_cnt=0, err_ovf=0, err_sos=0. Combinational outputs evaluate from reset state: in_ready=1, buf_push=0, buf_pop=0, busy=0.
- States: IDLE, FILL, DRAIN.
- in_ready is 1 in IDLE and FILL, 0 in DRAIN.
- IDLE:
  - in_valid & in_sos: buf_push=1, wr_cnt<=1. Next state is FILL, or DRAIN directly if BLK_LEN==1.
  - in_valid without in_sos: dropped, no push, no error.
- FILL:
  - in_valid: buf_push=1, wr_cnt<=wr_cnt+1.
  - When the accepted RE makes wr_cnt reach BLK_LEN: wr_cnt<=0, next state DRAIN.
  - in_sos with in_valid in FILL: err_sos<=1; the RE is still pushed as a normal entry and the block is not restarted.
- DRAIN:
  - dn_ready: buf_pop=1, rd_cnt<=rd_cnt+1.
  - On the pop that makes rd_cnt reach BLK_LEN: rd_cnt<=0, blk_cnt<=blk_cnt+1, next state IDLE.
  - in_valid in DRAIN: err_ovf<=1, RE discarded, no push.
- Read latency:
  - The buffer registers its output, so the entry popped in cycle t is presented in cycle t+1.
  - out_valid<=buf_pop and out_last<=(buf_pop & final pop), giving exactly 1-cycle latency aligned with buffer data.
  - The downstream stage must accept every cycle in which out_valid=1.
- Gaps: in_valid or dn_ready low pauses counting without state change; any gap length is allowed.
- Buffer capacity: BLK_LEN<=DEPTH and strict fill-then-drain mean the buffer never overflows or underflows; push is never issued when full, pop never when empty.
- Error flags are cleared only by reset.
- Reset mid-operation: async reset returns all state to reset values immediately. The buffer shares rst, so the partial block is discarded.
- busy = (state != IDLE).

Optional Feature:
- Macro: RE_BUF_SCHED_LEVEL_EN.
- Defined: adds output port level [CNT_W-1:0], a registered buffer occupancy (+1 on push, -1 on pop). Reset 0; equals BLK_LEN on entry to DRAIN; 0 on return to IDLE.
- Not defined: port and logic absent; all other behaviour identical.

Test Plan:
- Basic block, BLK_LEN=144:
  - Stimulus: in_sos+in_valid, then 143 back-to-back valids; dn_ready held 1.
  - Required: 144 pushes; state DRAIN the cycle after the 144th push; 144 pops; out_valid for 144 consecutive cycles starting 1 cycle after the first pop; out_last only on the 144th; blk_cnt=1; back to IDLE.
- Gappy traffic:
  - Stimulus: in_valid random 50%, dn_ready random 30%.
  - Required: push count = pop count = 144; out data order matches input order; no error flags.
- Overflow:
  - Stimulus: assert in_valid for 5 cycles during DRAIN.
  - Required: in_ready=0, no buf_push, err_ovf=1 stays set after DRAIN ends.
- Stray sos:
  - Stimulus: in_sos at entry 50 of FILL.
  - Required: err_sos=1; entry still pushed; block completes at 144 entries.
- Reset mid-DRAIN:
  - Stimulus: rst low after 70 pops.
  - Required: out_valid=0, blk_cnt=0, state IDLE; the next 144-entry block processes normally.
- Small block, BLK_LEN=1, two back-to-back sos pulses:
  - Required: push, pop, out_valid+out_last per block; blk_cnt=2.
  - RE_BUF_SCHED_LEVEL_EN build: level pulses 1 then 0.
